// File: rtl/vga_sprite_renderer_pkg.sv
// Shared constants, sprite bitmaps and pipeline types for the sprite renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_sprite_renderer_pkg;

  // RGB332 default colours
  localparam logic [7:0] RGB_ALIEN  = 8'h1C;
  localparam logic [7:0] RGB_PLAYER = 8'hE0;
  localparam logic [7:0] RGB_BULLET = 8'hFF;
  localparam logic [7:0] RGB_BG     = 8'h00;

  // Alien cell pitch is 32x16 with a 16x8 sprite at offset (0,0); the
  // cell geometry is baked into the rel_x/rel_y bit slices in the top.
  localparam logic [10:0] PLAYER_W_M1 = 11'd15;
  localparam logic [10:0] BULLET_W_M1 = 11'd1;
  localparam logic [10:0] SPR_H_M1    = 11'd7;

  typedef enum logic [1:0] {
    SPR_ALIEN_A = 2'd0,
    SPR_ALIEN_B = 2'd1,
    SPR_PLAYER  = 2'd2,
    SPR_NONE    = 2'd3
  } sprite_sel_e;

  // Bitmaps indexed [row]; bit 15 of a row is the leftmost pixel.
  // Concatenations list row 7 first so that index 0 is the top row.
  localparam logic [7:0][15:0] ALIEN_BMP_A = {
    16'hC003, 16'h300C, 16'h3FFC, 16'hF3CF,
    16'hFFFF, 16'h6FF6, 16'h3FFC, 16'hC003
  };
  localparam logic [7:0][15:0] ALIEN_BMP_B = {
    16'h3C3C, 16'h6006, 16'h3FFC, 16'hF3CF,
    16'hFFFF, 16'h6FF6, 16'h3FFC, 16'h0FF0
  };
  localparam logic [7:0][15:0] PLAYER_BMP = {
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'h7FFE, 16'h1FF8, 16'h03C0, 16'h0180
  };

  // Everything stage 2 needs about one pixel; the animation bit and the
  // alive bit travel with the pixel so a frame_start between the two
  // stages cannot split one pixel's decision across two game states.
  typedef struct packed {
    logic       von;
    logic       hs;
    logic       vs;
    logic       anim;
    logic       in_grid;
    logic       alive;
    logic       in_player;
    logic       in_bullet;
    logic [2:0] sub_y;
    logic [3:0] sub_x;
    logic [2:0] ply_y;
    logic [3:0] ply_x;
  } pix_s1_t;

  function automatic logic [1:0] alien_sel(input logic anim);
    return anim ? SPR_ALIEN_B : SPR_ALIEN_A;
  endfunction

endpackage

// File: rtl/vga_sprite_renderer_sprite_rom.sv
// Combinational sprite bitmap lookup: (sprite, row, column) -> pixel bit.
// Latency: 0 cycles.
// Backpressure: none, pure function of its inputs.
module vga_sprite_renderer_sprite_rom
  import vga_sprite_renderer_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic [2:0] i_sub_y,
  input  logic [3:0] i_sub_x,
  output logic       o_pix
);

  logic [15:0] w_row;

  // Select the bitmap row for the requested sprite.
  always_comb begin
    w_row = 16'h0000;
    case (i_sel)
      SPR_ALIEN_A: w_row = ALIEN_BMP_A[i_sub_y];
      SPR_ALIEN_B: w_row = ALIEN_BMP_B[i_sub_y];
      SPR_PLAYER:  w_row = PLAYER_BMP[i_sub_y];
      default:     w_row = 16'h0000;
    endcase
  end

  assign o_pix = w_row[4'd15 - i_sub_x];

endmodule

// File: rtl/vga_sprite_renderer.sv
// Pixel colour stage: renders alien grid, player and bullet into RGB332.
// Latency: 2 pix_en strobes from pixel/sync inputs to colour/sync outputs.
// Backpressure: none; the pipeline only advances on pix_en, holding otherwise.
module vga_sprite_renderer
  import vga_sprite_renderer_pkg::*;
#(
  parameter int         ALIEN_ROWS   = 5,
  parameter int         ALIEN_COLS   = 11,
  parameter int         PLAYER_Y     = 440,
  parameter int         ANIM_FRAMES  = 30,
  parameter logic       SYNC_IDLE    = 1'b1,
  parameter logic [7:0] COLOR_ALIEN  = RGB_ALIEN,
  parameter logic [7:0] COLOR_PLAYER = RGB_PLAYER,
  parameter logic [7:0] COLOR_BULLET = RGB_BULLET,
  parameter logic [7:0] COLOR_BG     = RGB_BG
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_en,
  input  logic [9:0]                     hcount,
  input  logic [9:0]                     vcount,
  input  logic                           video_on,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           frame_start,
  input  logic [9:0]                     player_x,
  input  logic [9:0]                     grid_x,
  input  logic [9:0]                     grid_y,
  input  logic [9:0]                     bullet_x,
  input  logic [9:0]                     bullet_y,
  input  logic                           bullet_active,
  input  logic [ALIEN_ROWS*ALIEN_COLS-1:0] alien_alive,
  output logic [7:0]                     vga_color,
  output logic                           hsync_out,
  output logic                           vsync_out
);

  localparam int          N_ALIEN = ALIEN_ROWS * ALIEN_COLS;
  localparam int          CNT_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [4:0]  N_COLS  = 5'(ALIEN_COLS);
  localparam logic [4:0]  N_ROWS  = 5'(ALIEN_ROWS);
  localparam logic [9:0]  COLS_10 = 10'(ALIEN_COLS);
  localparam logic [10:0] PY_LO   = 11'(PLAYER_Y);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  // Shadowed game state, frozen for the whole frame
  logic [9:0]         r_player_x, r_grid_x, r_grid_y, r_bullet_x, r_bullet_y;
  logic               r_bullet_active;
  logic [N_ALIEN-1:0] r_alive;

  // Animation state
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_anim;

  // Pipeline
  pix_s1_t            r_s1;
  pix_s1_t            w_s1_nxt;

  logic [9:0]         w_rel_x;
  logic [8:0]         w_rel_y;
  logic [4:0]         w_col, w_row;
  logic [9:0]         w_alien_idx;
  logic [N_ALIEN-1:0] w_sel_mask;
  logic               w_in_grid, w_in_player, w_in_bullet;
  logic [10:0]        w_h11, w_v11, w_px11, w_bx11, w_by11;
  logic               w_alien_pix, w_player_pix;
  logic [7:0]         w_color;

  // Capture game state at each frame start so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_player_x      <= '0;
      r_grid_x        <= '0;
      r_grid_y        <= '0;
      r_bullet_x      <= '0;
      r_bullet_y      <= '0;
      r_bullet_active <= 1'b0;
      r_alive         <= '0;
    end else if (frame_start) begin
      r_player_x      <= player_x;
      r_grid_x        <= grid_x;
      r_grid_y        <= grid_y;
      r_bullet_x      <= bullet_x;
      r_bullet_y      <= bullet_y;
      r_bullet_active <= bullet_active;
      r_alive         <= alien_alive;
    end
  end

  // Count frames and flip the alien animation bit every ANIM_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_anim      <= 1'b0;
    end else if (frame_start) begin
      if (r_frame_cnt == CNT_LAST) begin
        r_frame_cnt <= '0;
        r_anim      <= ~r_anim;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Stage 1 geometry: grid cell decode plus player/bullet box tests.
  // All box bounds are widened to 11 bits so edge+width cannot wrap.
  assign w_rel_x     = hcount - r_grid_x;
  assign w_rel_y     = 9'(vcount - r_grid_y);
  assign w_col       = w_rel_x[9:5];
  assign w_row       = w_rel_y[8:4];
  assign w_in_grid   = (hcount >= r_grid_x) && (vcount >= r_grid_y) &&
                       (w_col < N_COLS) && (w_row < N_ROWS) &&
                       !w_rel_x[4] && !w_rel_y[3];
  assign w_alien_idx = ({5'd0, w_row} * COLS_10) + {5'd0, w_col};
  assign w_sel_mask  = {{(N_ALIEN-1){1'b0}}, 1'b1} << w_alien_idx;

  assign w_h11  = {1'b0, hcount};
  assign w_v11  = {1'b0, vcount};
  assign w_px11 = {1'b0, r_player_x};
  assign w_bx11 = {1'b0, r_bullet_x};
  assign w_by11 = {1'b0, r_bullet_y};

  assign w_in_player = (w_h11 >= w_px11) && (w_h11 <= w_px11 + PLAYER_W_M1) &&
                       (w_v11 >= PY_LO)  && (w_v11 <= PY_LO + SPR_H_M1);
  assign w_in_bullet = r_bullet_active &&
                       (w_h11 >= w_bx11) && (w_h11 <= w_bx11 + BULLET_W_M1) &&
                       (w_v11 >= w_by11) && (w_v11 <= w_by11 + SPR_H_M1);

  // Pack everything stage 2 needs for this pixel.
  always_comb begin
    w_s1_nxt           = '0;
    w_s1_nxt.von       = video_on;
    w_s1_nxt.hs        = hsync_in;
    w_s1_nxt.vs        = vsync_in;
    w_s1_nxt.anim      = r_anim;
    w_s1_nxt.in_grid   = w_in_grid;
    w_s1_nxt.alive     = w_in_grid && |(r_alive & w_sel_mask);
    w_s1_nxt.in_player = w_in_player;
    w_s1_nxt.in_bullet = w_in_bullet;
    w_s1_nxt.sub_y     = w_rel_y[2:0];
    w_s1_nxt.sub_x     = w_rel_x[3:0];
    w_s1_nxt.ply_y     = 3'(vcount - 10'(PLAYER_Y));
    w_s1_nxt.ply_x     = 4'(hcount - r_player_x);
  end

  // Stage 1 register; sync resets to its idle level so it never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1    <= '0;
      r_s1.hs <= SYNC_IDLE;
      r_s1.vs <= SYNC_IDLE;
    end else if (pix_en) begin
      r_s1 <= w_s1_nxt;
    end
  end

  vga_sprite_renderer_sprite_rom u_alien_rom (
    .i_sel   (alien_sel(r_s1.anim)),
    .i_sub_y (r_s1.sub_y),
    .i_sub_x (r_s1.sub_x),
    .o_pix   (w_alien_pix)
  );

  vga_sprite_renderer_sprite_rom u_player_rom (
    .i_sel   (SPR_PLAYER),
    .i_sub_y (r_s1.ply_y),
    .i_sub_x (r_s1.ply_x),
    .o_pix   (w_player_pix)
  );

  // Stage 2 priority mux: bullet over player over alien over background.
  always_comb begin
    w_color = COLOR_BG;
    if (!r_s1.von) begin
      w_color = COLOR_BG;
    end else if (r_s1.in_bullet) begin
      w_color = COLOR_BULLET;
    end else if (r_s1.in_player && w_player_pix) begin
      w_color = COLOR_PLAYER;
    end else if (r_s1.in_grid && r_s1.alive && w_alien_pix) begin
      w_color = COLOR_ALIEN;
    end
  end

  // Output register keeps colour and sync aligned at the connector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_color <= COLOR_BG;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else if (pix_en) begin
      vga_color <= w_color;
      hsync_out <= r_s1.hs;
      vsync_out <= r_s1.vs;
    end
  end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Bench for vga_sprite_renderer: directed pixels against a frame-level model.
// Latency: model is a 2-deep queue of per-pixel colour decisions.
// Backpressure: n/a.
module tb_vga_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hcount, vcount;
  logic        video_on, hsync_in, vsync_in, frame_start;
  logic [9:0]  player_x, grid_x, grid_y, bullet_x, bullet_y;
  logic        bullet_active;
  logic [54:0] alien_alive;
  logic [7:0]  vga_color;
  logic        hsync_out, vsync_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  vga_sprite_renderer #(.ANIM_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_start(frame_start), .player_x(player_x), .grid_x(grid_x),
    .grid_y(grid_y), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .alien_alive(alien_alive),
    .vga_color(vga_color), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Reference bitmaps, bit 15 = leftmost pixel, index 0 = top row
  logic [15:0] ab0 [8] = '{16'hC003, 16'h3FFC, 16'h6FF6, 16'hFFFF,
                           16'hF3CF, 16'h3FFC, 16'h300C, 16'hC003};
  logic [15:0] ab1 [8] = '{16'h0FF0, 16'h3FFC, 16'h6FF6, 16'hFFFF,
                           16'hF3CF, 16'h3FFC, 16'h6006, 16'h3C3C};
  logic [15:0] pb  [8] = '{16'h0180, 16'h03C0, 16'h1FF8, 16'h7FFE,
                           16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

  // Model state: frame-latched game state and number of frame starts seen
  int          sh_px = 0, sh_gx = 0, sh_gy = 0, sh_bx = 0, sh_by = 0;
  logic        sh_ba = 1'b0;
  logic [54:0] sh_alive = '0;
  int          nfs = 0;
  logic [7:0]  m1c = 8'h00, m2c = 8'h00;
  logic        m1hs = 1'b1, m1vs = 1'b1, m2hs = 1'b1, m2vs = 1'b1;

  function automatic logic [7:0] model_color(input int h, input int v, input logic von);
    int dx, dy, c, r, anim;
    logic [15:0] row;
    if (!von) return 8'h00;
    if (sh_ba && h >= sh_bx && h <= sh_bx + 1 && v >= sh_by && v <= sh_by + 7)
      return 8'hFF;
    if (h >= sh_px && h <= sh_px + 15 && v >= 440 && v <= 447) begin
      row = pb[v - 440];
      if (row[15 - (h - sh_px)]) return 8'hE0;
    end
    if (h >= sh_gx && v >= sh_gy) begin
      dx = h - sh_gx;
      dy = v - sh_gy;
      c  = (dx / 32) % 32;
      r  = (dy / 16) % 32;
      if (c < 11 && r < 5 && (dx % 32) < 16 && (dy % 16) < 8 && sh_alive[r*11 + c]) begin
        anim = (nfs / 2) % 2;
        row  = (anim == 1) ? ab1[dy % 16] : ab0[dy % 16];
        if (row[15 - (dx % 32)]) return 8'h1C;
      end
    end
    return 8'h00;
  endfunction

  // Model: each strobe shifts the pixel decision queue by one
  always @(posedge clk) begin
    if (!rst) begin
      sh_px <= 0; sh_gx <= 0; sh_gy <= 0; sh_bx <= 0; sh_by <= 0;
      sh_ba <= 1'b0; sh_alive <= '0; nfs <= 0;
      m1c <= 8'h00; m1hs <= 1'b1; m1vs <= 1'b1;
      m2c <= 8'h00; m2hs <= 1'b1; m2vs <= 1'b1;
    end else begin
      if (pix_en) begin
        m2c  <= m1c;
        m2hs <= m1hs;
        m2vs <= m1vs;
        m1c  <= model_color(int'(hcount), int'(vcount), video_on);
        m1hs <= hsync_in;
        m1vs <= vsync_in;
      end
      if (frame_start) begin
        sh_px <= int'(player_x); sh_gx <= int'(grid_x); sh_gy <= int'(grid_y);
        sh_bx <= int'(bullet_x); sh_by <= int'(bullet_y);
        sh_ba <= bullet_active; sh_alive <= alien_alive;
        nfs   <= nfs + 1;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ({vga_color, hsync_out, vsync_out} !== {m2c, m2hs, m2vs}) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got col=%h hs=%b vs=%b expected col=%h hs=%b vs=%b",
                 $time, vga_color, hsync_out, vsync_out, m2c, m2hs, m2vs);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    pix_en      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic strobe(input int h, input int v, input logic von,
                        input logic hs, input logic fs);
    @(negedge clk);
    pix_en      = 1'b1;
    frame_start = fs;
    hcount      = 10'(h);
    vcount      = 10'(v);
    video_on    = von;
    hsync_in    = hs;
    vsync_in    = 1'b1;
  endtask

  task automatic fstart();
    @(negedge clk);
    pix_en      = 1'b0;
    frame_start = 1'b1;
    idle();
  endtask

  // Render one pixel through both stages, then check the colour
  task automatic render_chk(input string name, input int h, input int v,
                            input logic von, input logic [7:0] exp);
    strobe(h, v, von, 1'b1, 1'b0);
    idle();
    strobe(h, v, von, 1'b1, 1'b0);
    idle();
    check(name, vga_color, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pix_en = 1'b0; frame_start = 1'b0;
    hcount = '0; vcount = '0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    player_x = 10'd200; grid_x = 10'd100; grid_y = 10'd50;
    bullet_x = 10'd205; bullet_y = 10'd442; bullet_active = 1'b1;
    alien_alive = '1;
    alien_alive[12] = 1'b0;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_color", vga_color, 8'h00);
    check("rst_hsync", {7'd0, hsync_out}, 8'h01);
    check("rst_vsync", {7'd0, vsync_out}, 8'h01);
    rst = 1'b1;
    repeat (3) idle();
    check("idle_color", vga_color, 8'h00);
    check("idle_hsync", {7'd0, hsync_out}, 8'h01);

    // Before any frame start the shadows are zero: player at x=0, all dead
    render_chk("boot_player_shadow0", 3, 442, 1'b1, 8'hE0);
    render_chk("boot_grid_dead", 0, 0, 1'b1, 8'h00);

    fstart();  // frame 1, animation bit 0
    render_chk("player_pre_lat", 203, 442, 1'b1, 8'hE0);

    // Latency: colour and hsync move exactly at the 2nd strobe
    strobe(100, 50, 1'b1, 1'b0, 1'b0);
    idle();
    check("lat_hold_color", vga_color, 8'hE0);
    check("lat_hold_hsync", {7'd0, hsync_out}, 8'h01);
    strobe(116, 50, 1'b1, 1'b1, 1'b0);
    idle();
    check("lat_alien_color", vga_color, 8'h1C);
    check("lat_hsync_low", {7'd0, hsync_out}, 8'h00);

    render_chk("dead_alien_r1c1", 133, 66, 1'b1, 8'h00);
    render_chk("live_alien_r1c0", 100, 66, 1'b1, 8'h1C);
    render_chk("gap_column", 116, 50, 1'b1, 8'h00);
    render_chk("bullet_over_player", 205, 442, 1'b1, 8'hFF);
    render_chk("player_pixel", 203, 442, 1'b1, 8'hE0);
    render_chk("bullet_only", 205, 448, 1'b1, 8'hFF);
    render_chk("blank_alien", 100, 50, 1'b0, 8'h00);

    // Animation bit over frames 2..5 with ANIM_FRAMES=2: 1,1,0,0
    fstart(); render_chk("anim_f2", 100, 50, 1'b1, 8'h00);
    fstart(); render_chk("anim_f3", 100, 50, 1'b1, 8'h00);
    fstart(); render_chk("anim_f4", 100, 50, 1'b1, 8'h1C);
    fstart(); render_chk("anim_f5", 100, 50, 1'b1, 8'h1C);

    // Mid-frame player move is held back until the next frame start
    player_x = 10'd300;
    render_chk("shadow_old_pos", 203, 442, 1'b1, 8'hE0);
    render_chk("shadow_new_hidden", 303, 442, 1'b1, 8'h00);
    fstart();
    render_chk("shadow_new_pos", 303, 442, 1'b1, 8'hE0);
    render_chk("shadow_old_gone", 203, 442, 1'b1, 8'h00);

    // Frame start coinciding with a strobe: that pixel uses pre-update state
    player_x = 10'd200;
    strobe(203, 442, 1'b1, 1'b1, 1'b1);
    idle();
    strobe(203, 442, 1'b1, 1'b1, 1'b0);
    idle();
    check("simul_pre_update", vga_color, 8'h00);
    strobe(203, 442, 1'b1, 1'b1, 1'b0);
    idle();
    check("simul_post_update", vga_color, 8'hE0);

    // Reset in mid-frame with pix_en high
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b1;
    idle();
    rst = 1'b1;
    check("mid_rst_color", vga_color, 8'h00);
    check("mid_rst_hsync", {7'd0, hsync_out}, 8'h01);
    strobe(3, 442, 1'b1, 1'b0, 1'b0);
    idle();
    check("mid_rst_1st_color", vga_color, 8'h00);
    check("mid_rst_1st_hsync", {7'd0, hsync_out}, 8'h01);
    strobe(3, 442, 1'b1, 1'b1, 1'b0);
    idle();
    check("mid_rst_2nd_color", vga_color, 8'hE0);
    check("mid_rst_2nd_hsync", {7'd0, hsync_out}, 8'h00);

    repeat (2) idle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
